// File: rtl/multiport_regfile_param_if.sv
// Operand-fetch / writeback bundle for multiport_regfile_param.
// Read, write and status signals are packed per port: port i occupies [i*W +: W].
interface multiport_regfile_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  logic                     wr_conflict;
  logic [15:0]              conflict_cnt;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, ready, wr_conflict, conflict_cnt
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, ready, wr_conflict, conflict_cnt
  );
endinterface

// File: rtl/multiport_regfile_param.sv
// Parametrised multi-port register file with post-reset clear sweep, registered reads and write-conflict reporting.
// Optional RF_BYPASS_EN: a read colliding with a committing write returns the new data instead of the old entry.
module multiport_regfile_param #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  multiport_regfile_param_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     sweep_we_s;
  logic                     run_s;
  logic                     ready_d;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_WR-1:0]        shadow_s;
  logic [NUM_WR-1:0]        wr_commit_s;
  logic                     conflict_s;
  logic [DATA_W-1:0]        rd_word_s [NUM_RD];

  logic                     ready_q;
  logic [NUM_RD-1:0]        rd_valid_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic                     wr_conflict_q;
  logic [15:0]              conflict_cnt_q;

  // An address is live when it maps to a real entry that is not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < DEPTH_EXT);
    is_zero  = (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    return in_range && !is_zero;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // FSM state register and sweep pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: sweep every entry once, then run until the next reset
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ptr_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_INIT;
          ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        ptr_d   = ptr_q;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM outputs: sweep write strobe, run qualifier for accesses, and next ready value
  always_comb begin
    sweep_we_s = 1'b0;
    run_s      = 1'b0;
    case (state_q)
      ST_INIT: sweep_we_s = !reset;
      ST_RUN:  run_s      = !reset;
      default: begin
        sweep_we_s = 1'b0;
        run_s      = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Write arbitration: a port is shadowed by any lower-index enabled port on the same address
  always_comb begin
    shadow_s    = {NUM_WR{1'b0}};
    wr_commit_s = {NUM_WR{1'b0}};
    conflict_s  = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        shadow_s[j] = shadow_s[j] | ((k < j) && bus.wr_en[j] && bus.wr_en[k] &&
                      (bus.wr_addr[j*ADDR_W +: ADDR_W] == bus.wr_addr[k*ADDR_W +: ADDR_W]));
      end
      conflict_s     = conflict_s | (run_s & shadow_s[j]);
      wr_commit_s[j] = run_s & bus.wr_en[j] & ~shadow_s[j] &
                       addr_live(bus.wr_addr[j*ADDR_W +: ADDR_W]);
    end
  end

  // Read word selection, with optional forwarding of the winning write
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (addr_live(bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_word_s[i] = mem_q[to_idx(bus.rd_addr[i*ADDR_W +: ADDR_W])];
      end else begin
        rd_word_s[i] = {DATA_W{1'b0}};
      end
`ifdef RF_BYPASS_EN
      for (int j = NUM_WR - 1; j >= 0; j--) begin
        rd_word_s[i] = (wr_commit_s[j] &&
                        (bus.wr_addr[j*ADDR_W +: ADDR_W] == bus.rd_addr[i*ADDR_W +: ADDR_W]))
                       ? bus.wr_data[j*DATA_W +: DATA_W] : rd_word_s[i];
      end
`endif
    end
  end

  // Storage: cleared by the sweep rather than by reset, so no reset branch here
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem_q[ptr_q] <= {DATA_W{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_commit_s[j]) begin
          mem_q[to_idx(bus.wr_addr[j*ADDR_W +: ADDR_W])] <= bus.wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered outputs: ready, read data/valid, conflict pulse and saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q        <= 1'b0;
      rd_valid_q     <= {NUM_RD{1'b0}};
      rd_data_q      <= {(NUM_RD*DATA_W){1'b0}};
      wr_conflict_q  <= 1'b0;
      conflict_cnt_q <= 16'h0000;
    end else begin
      ready_q       <= ready_d;
      rd_valid_q    <= run_s ? bus.rd_en : {NUM_RD{1'b0}};
      wr_conflict_q <= conflict_s;
      for (int i = 0; i < NUM_RD; i++) begin
        if (run_s && bus.rd_en[i]) begin
          rd_data_q[i*DATA_W +: DATA_W] <= rd_word_s[i];
        end
      end
      if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'h0001;
      end
    end
  end

  assign bus.ready        = ready_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.wr_conflict  = wr_conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_multiport_regfile_param.sv
// Scoreboard bench for multiport_regfile_param: directed and random traffic checked against an array/map model.
module tb_multiport_regfile_param;
  localparam int DW = 64, DEPTH = 32, AW = 6, NR = 4, NW = 2, ZR = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multiport_regfile_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_if ();

  multiport_regfile_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(ZR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    bit            rst;
    bit            ready;
    logic [NR-1:0] valid;
    bit            conflict;
    logic [15:0]   cnt;
  } ctl_t;

  ctl_t          ctl_q[$];
  logic [DW-1:0] rd_q[NR][$];
  logic [DW-1:0] mmem[DEPTH];
  logic [DW-1:0] last_q[NR];
  int            sweep_cnt;
  logic [15:0]   mcnt;
  int            checks = 0;
  int            errors = 0;
  ctl_t          mc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZR != 0 && a == 0);
  endfunction

  task automatic idle();
    bus_if.rd_en = '0;
    bus_if.wr_en = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    bus_if.rd_en[i] = 1'b1;
    bus_if.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.wr_en[j] = 1'b1;
    bus_if.wr_addr[j*AW +: AW] = a;
    bus_if.wr_data[j*DW +: DW] = d;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 63));
      1:       return AW'($urandom_range(0, 7));
      default: return AW'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NR; i++) begin
      bus_if.rd_en[i] = 1'($urandom_range(0, 1));
      bus_if.rd_addr[i*AW +: AW] = pick_addr();
    end
    for (int j = 0; j < NW; j++) begin
      bus_if.wr_en[j] = 1'($urandom_range(0, 1));
      bus_if.wr_addr[j*AW +: AW] = pick_addr();
      bus_if.wr_data[j*DW +: DW] = {$urandom(), $urandom()};
    end
  endtask

  // Model one clock edge with the current inputs, queue expectations, then advance.
  task automatic step();
    ctl_t          c;
    bit            conf;
    logic [DW-1:0] wmap[int];
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    c.rst = reset; c.conflict = 0; c.valid = '0;
    if (reset) begin
      sweep_cnt = 0;
      mcnt = 16'h0;
    end else if (sweep_cnt < DEPTH) begin
      sweep_cnt++;
      if (sweep_cnt == DEPTH) foreach (mmem[k]) mmem[k] = '0;
    end else begin
      conf = 0;
      for (int j = 0; j < NW; j++) begin
        if (bus_if.wr_en[j]) begin
          a = bus_if.wr_addr[j*AW +: AW];
          if (wmap.exists(int'(a))) conf = 1;
          else wmap[int'(a)] = bus_if.wr_data[j*DW +: DW];
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (bus_if.rd_en[i]) begin
          a = bus_if.rd_addr[i*AW +: AW];
          v = '0;
          if (addr_ok(a)) begin
            v = mmem[int'(a)];
`ifdef RF_BYPASS_EN
            if (wmap.exists(int'(a))) v = wmap[int'(a)];
`endif
          end
          rd_q[i].push_back(v);
        end
      end
      foreach (wmap[k]) if (addr_ok(AW'(k))) mmem[k] = wmap[k];
      if (conf) begin
        c.conflict = 1;
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'h1;
      end
      c.valid = bus_if.rd_en;
    end
    c.ready = (sweep_cnt >= DEPTH);
    c.cnt = mcnt;
    ctl_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares status every cycle and pops read data whenever the DUT flags it valid.
  always @(negedge clk) begin
    if (ctl_q.size() != 0) begin
      mc = ctl_q.pop_front();
      chk("ready", 64'(bus_if.ready), 64'(mc.ready));
      chk("rd_valid", 64'(bus_if.rd_valid), 64'(mc.valid));
      chk("wr_conflict", 64'(bus_if.wr_conflict), 64'(mc.conflict));
      chk("conflict_cnt", 64'(bus_if.conflict_cnt), 64'(mc.cnt));
      if (mc.rst) foreach (last_q[i]) last_q[i] = '0;
      for (int i = 0; i < NR; i++) begin
        if (bus_if.rd_valid[i] === 1'b1) begin
          if (rd_q[i].size() == 0) begin
            chk("rd_unexpected", 64'(i), 64'hFFFF_FFFF);
          end else begin
            last_q[i] = rd_q[i].pop_front();
          end
        end
        chk("rd_data", bus_if.rd_data[i*DW +: DW], last_q[i]);
      end
    end
  end

  initial begin
    idle();
    bus_if.rd_addr = '0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (DEPTH) step();
    // Every entry reads as zero after the sweep
    for (int b = 0; b < DEPTH; b += NR) begin
      idle();
      for (int i = 0; i < NR; i++) set_rd(i, AW'(b + i));
      step();
    end
    // Two writes to different entries, then readback
    idle(); set_wr(0, 6'd5, 64'hDEAD_BEEF_0000_0001); set_wr(1, 6'd9, 64'h1234); step();
    idle(); set_rd(0, 6'd5); set_rd(1, 6'd9); set_rd(2, 6'd5); set_rd(3, 6'd9); step();
    // Same-address collision: port 0 wins
    idle(); set_wr(0, 6'd7, 64'hAAAA); set_wr(1, 6'd7, 64'hBBBB); step();
    idle(); set_rd(0, 6'd7); step();
    // Zero register and out-of-range address
    idle(); set_wr(0, 6'd0, 64'hFFFF); set_wr(1, 6'd40, 64'h77); set_rd(1, 6'd40); step();
    idle(); set_rd(0, 6'd0); set_rd(1, 6'd40); step();
    // Read/write collision on entry 3
    idle(); set_wr(1, 6'd3, 64'h55); set_rd(2, 6'd3); step();
    idle(); set_rd(2, 6'd3); step();
    idle(); step();
    // Random traffic
    repeat (400) begin
      rand_inputs();
      step();
    end
    // Reset mid-sweep with traffic presented during the sweep
    reset = 1'b1; idle(); step(); reset = 1'b0;
    repeat (10) begin rand_inputs(); step(); end
    reset = 1'b1; step(); reset = 1'b0;
    repeat (DEPTH + 4) begin rand_inputs(); step(); end
    // Counter saturation
    repeat (70000) begin
      rand_inputs();
      set_wr(1, bus_if.wr_addr[0 +: AW], {$urandom(), $urandom()});
      bus_if.wr_en[0] = 1'b1;
      step();
    end
    repeat (50) begin rand_inputs(); step(); end
    idle(); step(); step();
    @(negedge clk);
    #1;
    chk("ctl_drained", 64'(ctl_q.size()), 64'd0);
    for (int i = 0; i < NR; i++) chk("rd_drained", 64'(rd_q[i].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
